ssd_scan_ctrl: RTL and testbench

//  Scan scheduler for the 4-digit multiplexed seven-segment display. Holds a

---
 rtl/ssd_scan_if.sv | 23 ++
 rtl/ssd_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_if.sv
// Write-side handshake bundle for the seven-segment scan controller.
// A writer offers a 4-digit value plus a per-digit blank mask. The
// controller accepts it when its pending buffer is empty.
interface ssd_scan_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_blank;

    modport master (
        output wr_valid,
        output wr_data,
        output wr_blank,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        input  wr_blank,
        output wr_ready
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Scan scheduler for a 4-digit multiplexed seven-segment display.
// Each digit slot opens with BLANK dead cycles (all anodes off) against
// ghosting, then drives the anode of the current digit for the rest of the
// DIV-cycle slot. New values wait in a pending buffer and only reach the
// active buffer at a frame boundary, or at once while the scan is off, so a
// frame never mixes old and new digits.
module ssd_scan_ctrl #(
    parameter int DIV   = 131072,
    parameter int BLANK = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    ssd_scan_if.slave     wr,
    output logic [3:0]    an,
    output logic [3:0]    digit_out,
    output logic [1:0]    digit_idx,
    output logic          frame_done
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK - 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       idx, idx_n;

    logic [15:0]      pend_data;
    logic [3:0]       pend_blank;
    logic             pend_full;

    logic [15:0]      act_data, act_data_n;
    logic [3:0]       act_blank, act_blank_n;

    logic             accept;
    logic             frame_end;
    logic             commit;
    logic [3:0]       an_n;
    logic [3:0]       digit_n;

    assign wr.wr_ready = ~pend_full;
    assign accept      = wr.wr_valid & ~pend_full;

    // The frame ends on the last cycle of the digit-3 lit phase; dropping en
    // on that same edge takes priority, so no frame end is reported then.
    assign frame_end = en && (state == S_ON) && (idx == 2'd3) && (cnt == CNT_LAST);

    // Commit looks at pending state before the edge, so a write accepted on a
    // frame-end edge waits for the following frame end.
    assign commit = pend_full && (frame_end || (state == S_OFF));

    // Next scan position: slot counter, digit index and phase.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        if (!en) begin
            state_n = S_OFF;
            cnt_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_n = S_BLANK;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
                S_BLANK: begin
                    cnt_n = cnt + CNT_W'(1);
                    if (cnt == CNT_BLANK_LAST) begin
                        state_n = S_ON;
                    end
                end
                S_ON: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n   = '0;
                        idx_n   = idx + 2'd1;
                        state_n = S_BLANK;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = S_OFF;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            endcase
        end
    end

    // Post-edge active buffer and the display outputs derived from it, so the
    // registered outputs match the scan position after the same edge.
    always_comb begin
        act_data_n  = act_data;
        act_blank_n = act_blank;
        if (commit) begin
            act_data_n  = pend_data;
            act_blank_n = pend_blank;
        end
        an_n = 4'b1111;
        if ((state_n == S_ON) && !act_blank_n[idx_n]) begin
            an_n = ~(4'b0001 << idx_n);
        end
        digit_n = act_data_n[{idx_n, 2'b00} +: 4];
    end

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OFF;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // Pending buffer: filled by an accepted write, emptied by a commit.
    // Both cannot happen together since accept needs it empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full  <= 1'b0;
            pend_data  <= '0;
            pend_blank <= '0;
        end else if (accept) begin
            pend_full  <= 1'b1;
            pend_data  <= wr.wr_data;
            pend_blank <= wr.wr_blank;
        end else if (commit) begin
            pend_full  <= 1'b0;
        end
    end

    // Active buffer shown on the display; dark until the first commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data  <= '0;
            act_blank <= 4'b1111;
        end else begin
            act_data  <= act_data_n;
            act_blank <= act_blank_n;
        end
    end

    // Registered display outputs and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 4'b1111;
            digit_out  <= '0;
            frame_done <= 1'b0;
        end else begin
            an         <= an_n;
            digit_out  <= digit_n;
            frame_done <= frame_end;
        end
    end

    assign digit_idx = idx;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with DIV=8, BLANK=2 (8-cycle slot,
// 32-cycle frame). Outputs are sampled on the falling clock edge.
module tb_ssd_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] an;
    logic [3:0] digit_out;
    logic [1:0] digit_idx;
    logic       frame_done;

    int checks;
    int failures;

    ssd_scan_if bus ();

    ssd_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr         (bus),
        .an         (an),
        .digit_out  (digit_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next frame_done pulse, starting one cycle on.
    task automatic wait_fd(input int max);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < max);
        chk("wait_frame_done", frame_done, 1);
    endtask

    // Called on a frame_done sample; checks one full frame of expected output.
    task automatic check_frame(input logic [15:0] data, input logic [3:0] blank);
        logic [3:0] exp_an;
        for (int k = 0; k < 32; k++) begin
            int s;
            int c;
            s = k / 8;
            c = k % 8;
            exp_an = 4'b1111;
            if (c >= 2 && !blank[s]) exp_an = ~(4'b0001 << s);
            chk("frame_an", an, exp_an);
            chk("frame_digit", digit_out, data[4*s +: 4]);
            chk("frame_idx", digit_idx, s);
            chk("frame_done", frame_done, (k == 0) ? 1 : 0);
            @(negedge clk);
        end
    endtask

    initial begin
        int bad;
        int fd1;
        int fd2;
        int n;

        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        en           = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_blank = '0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_an", an, 4'b1111);
        chk("rst_digit", digit_out, 0);
        chk("rst_idx", digit_idx, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wr_ready", bus.wr_ready, 1);

        // Scan enabled with no write: dark display, frame_done every 32 cycles
        rst_n = 1'b1;
        en    = 1'b1;
        bad   = 0;
        fd1   = -1;
        fd2   = -1;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (an !== 4'b1111) bad++;
            if (frame_done === 1'b1) begin
                if (fd1 < 0) fd1 = i;
                else if (fd2 < 0) fd2 = i;
            end
        end
        chk("dark_an_cycles", bad, 0);
        chk("first_frame_done", fd1, 33);
        chk("second_frame_done", fd2, 65);
        chk("idle_wr_ready", bus.wr_ready, 1);

        // Write 8469, commit at next frame end, then one full frame checked
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'h8469;
        bus.wr_blank = 4'b0000;
        @(negedge clk);
        chk("wr1_ready_low", bus.wr_ready, 0);
        bus.wr_valid = 1'b0;
        wait_fd(40);
        chk("wr1_ready_back", bus.wr_ready, 1);
        check_frame(16'h8469, 4'b0000);

        // Back-to-back writes: B waits for A's commit at the frame end
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'h1234;
        bus.wr_blank = 4'b0000;
        @(negedge clk);
        chk("wrA_ready_low", bus.wr_ready, 0);
        bus.wr_data  = 16'h5678;
        bus.wr_blank = 4'b0010;
        n = 1;
        while (bus.wr_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("wrB_wait_cycles", n, 32);
        chk("wrB_ready_at_frame_done", frame_done, 1);
        check_frame(16'h1234, 4'b0000);
        chk("wrB_committed_ready", bus.wr_ready, 1);
        bus.wr_valid = 1'b0;
        check_frame(16'h5678, 4'b0010);

        // Write accepted on the frame-end edge waits a whole frame
        repeat (31) @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'hABCD;
        bus.wr_blank = 4'b0000;
        @(negedge clk);
        chk("edge_wr_frame_done", frame_done, 1);
        chk("edge_wr_accepted", bus.wr_ready, 0);
        bus.wr_valid = 1'b0;
        check_frame(16'h5678, 4'b0010);
        chk("edge_wr_ready_back", bus.wr_ready, 1);
        check_frame(16'hABCD, 4'b0000);

        // Disable mid-ON of digit 2, write while disabled, re-enable
        repeat (20) @(negedge clk);
        chk("d2_on_an", an, 4'b1011);
        chk("d2_on_idx", digit_idx, 2);
        chk("d2_on_digit", digit_out, 4'hB);
        en = 1'b0;
        @(negedge clk);
        chk("off_an", an, 4'b1111);
        chk("off_idx", digit_idx, 0);
        chk("off_digit", digit_out, 4'hD);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'h0F1E;
        bus.wr_blank = 4'b0000;
        @(negedge clk);
        chk("off_wr_ready_low", bus.wr_ready, 0);
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("off_commit_ready", bus.wr_ready, 1);
        chk("off_commit_digit", digit_out, 4'hE);
        chk("off_commit_an", an, 4'b1111);
        en = 1'b1;
        @(negedge clk);
        chk("reen_dead0_an", an, 4'b1111);
        chk("reen_dead0_idx", digit_idx, 0);
        @(negedge clk);
        chk("reen_dead1_an", an, 4'b1111);
        @(negedge clk);
        chk("reen_on_an", an, 4'b1110);
        chk("reen_on_digit", digit_out, 4'hE);

        // Async reset between edges during ON drops a pending write
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'h2222;
        bus.wr_blank = 4'b0000;
        @(negedge clk);
        chk("pre_rst_ready_low", bus.wr_ready, 0);
        chk("pre_rst_an", an, 4'b1110);
        bus.wr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", an, 4'b1111);
        chk("async_rst_ready", bus.wr_ready, 1);
        chk("async_rst_digit", digit_out, 0);
        chk("async_rst_idx", digit_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an !== 4'b1111) bad++;
        end
        chk("post_rst_dark_cycles", bad, 0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'h3210;
        bus.wr_blank = 4'b0000;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        wait_fd(40);
        check_frame(16'h3210, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
